apb2lb_timeout: RTL
===================

# apb2lb_timeout

Parametrised APB-to-local-bus bridge with registered local-bus strobes, wait-state handshaking and a bus-timeout watchdog. It sits between the APB interconnect and a generated register map's local bus. It converts each APB transfer into exactly one local-bus write or read. A transfer the register map never acknowledges ends with PSLVERR instead of hanging the APB.

## Interface
Parameters:
- ADDR_W, 16, address width of both APB and local bus
- DATA_W, 32, data width; multiple of 8
- STRB_W, DATA_W/8, byte-strobe width (derived, not overridden)
- TIMEOUT, 255, maximum local-bus wait in cycles, range 1..65535; 0 disables the watchdog

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  reset, synchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB direction; 1 = write
- paddr  in  ADDR_W  APB address
- pwdata  in  DATA_W  APB write data
- pstrb  in  STRB_W  APB byte strobes
- prdata  out  DATA_W  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- waddr  out  ADDR_W  local-bus write address
- wdata  out  DATA_W  local-bus write data
- wstrb  out  STRB_W  local-bus write strobes
- wen  out  1  local-bus write request
- wready  in  1  local-bus write accept
- raddr  out  ADDR_W  local-bus read address
- ren  out  1  local-bus read request, one-cycle pulse
- rdata  in  DATA_W  local-bus read data
- rvalid  in  1  local-bus read data valid
- tmo_cnt  out  8  count of timed-out transfers, saturating

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT, RESP.
- IDLE:
  - On psel=1 and penable=0 (APB setup), register paddr, pwdata and pstrb.
  - If pwrite=1, go to WR_WAIT; otherwise go to RD_WAIT.
  - Clear the wait counter.
- WR_WAIT:
  - wen=1 with waddr, wdata and wstrb stable.
  - The write completes in a cycle where wen=1 and wready=1.
  - On completion, wen drops on the next edge and the FSM goes to RESP with err=0.
- RD_WAIT:
  - ren=1 only in the first cycle of the state.
  - raddr stays stable for the whole state.
  - The read completes on the first cycle with rvalid=1; rvalid in the same cycle as ren is legal.
  - Capture rdata into prdata and go to RESP with err=0.
- Watchdog (TIMEOUT≠0):
  - The wait counter is $clog2(TIMEOUT+1) bits wide. It increments in every WR_WAIT/RD_WAIT cycle without completion.
  - When TIMEOUT cycles pass without completion, go to RESP with err=1. In that case prdata=0, wen drops and tmo_cnt increments, saturating at 255.
  - If completion and timeout fall in the same cycle, completion wins.
- RESP:
  - pready=1 and pslverr=err for exactly one cycle, then return to IDLE.
- prdata holds its last value between transfers. It updates only on read completion or on a read timeout.
- A write transfer does not modify prdata.
- Local-bus outputs waddr/raddr/wdata/wstrb hold their last captured values outside transfers.
- psel deasserted mid-transfer (APB violation): the local-bus transaction still runs to completion or timeout, and RESP still pulses.
- With TIMEOUT=0, WR_WAIT/RD_WAIT wait indefinitely and tmo_cnt stays 0.

## Timing
- Reset (rst=1 at a clk edge):
  - At the edge: state=IDLE; pready, pslverr, wen, ren=0; prdata, waddr, raddr, wdata, wstrb=0; tmo_cnt=0; wait counter=0.
  - Reset mid-transfer abandons the transfer with no pready pulse.
- All outputs are registered; no combinational path runs from input to output.
- Write, wready already high: setup at edge E0, wen=1 in cycle E1, pready=1 in cycle E2. This is one APB wait state.
- Read, rvalid in the ren cycle: ren=1 in E1, pready=1 with valid prdata in E2.
- Each extra cycle of wready=0 or rvalid=0 adds one cycle to pready.
- Timeout, TIMEOUT=N: wen is high for cycles E1..EN, and pready=pslverr=1 in E(N+1).
- Back-to-back: a new setup is accepted on the cycle after RESP. APB timing guarantees this: the setup follows the cycle in which pready=1.

## Test plan
- Write, wready=1 constantly: paddr=0x0010, pwdata=0xDEADBEEF, pstrb=0xF -> one-cycle wen with waddr=0x0010, wdata=0xDEADBEEF, wstrb=0xF; pready on the 2nd cycle after setup; pslverr=0.
- Read with rvalid 3 cycles after ren, rdata=0x12345678 -> ren pulses exactly once; pready 4 cycles after the ren cycle; prdata=0x12345678; pslverr=0.
- TIMEOUT=4, write with wready stuck 0 -> wen high exactly 4 cycles; pready=pslverr=1 in the next cycle; tmo_cnt=1. A following read with rvalid=1 completes with pslverr=0.
- TIMEOUT=4, rvalid asserted in the 4th wait cycle -> completion wins: pslverr=0, prdata=rdata, tmo_cnt unchanged.
- 300 consecutive timed-out reads -> tmo_cnt saturates at 255; every read returns prdata=0, pslverr=1.
- rst pulsed while in WR_WAIT -> next cycle wen=0, pready=0 and all outputs at reset values; a subsequent write completes normally.

Source files
------------

// File: rtl/apb2lb_timeout.sv
// APB-to-local-bus bridge with registered local-bus strobes, wait-state handshaking
// and a bus-timeout watchdog. Every output comes straight from a flop.
module apb2lb_timeout #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned STRB_W = DATA_W / 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // APB side
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  // Local-bus write channel
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wen,
  input  logic              wready,
  // Local-bus read channel
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  // Status
  output logic [7:0]        tmo_cnt
);

  // A zero-width counter is illegal, so TIMEOUT=0 keeps a dummy 1-bit counter.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StWrWait, StRdWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              tmo_hit;

  // Watchdog fires on the TIMEOUT-th wait cycle without completion.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    prdata_d  = prdata_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          waddr_d = paddr;
          raddr_d = paddr;
          wdata_d = pwdata;
          wstrb_d = pstrb;
          cnt_d   = '0;
          if (pwrite) begin
            state_d = StWrWait;
            wen_d   = 1'b1;
          end else begin
            state_d = StRdWait;
            ren_d   = 1'b1;
          end
        end
      end

      StWrWait: begin
        // wen is always high here, so wready alone marks completion.
        if (wready) begin
          state_d  = StResp;
          pready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (tmo_hit) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
          end else begin
            wen_d = 1'b1;
          end
        end
      end

      StRdWait: begin
        if (rvalid) begin
          state_d  = StResp;
          pready_d = 1'b1;
          prdata_d = rdata;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (tmo_hit) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      prdata_q  <= '0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      prdata_q  <= prdata_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      tmo_q     <= tmo_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wen     = wen_q;
  assign raddr   = raddr_q;
  assign ren     = ren_q;
  assign tmo_cnt = tmo_q;

endmodule
